// File: rtl/bpu_pkg.sv
// Shared definitions for the local-history branch predictor: 2-bit counter
// encodings, MIPS branch opcode constants, counter step helper, FSM states.
package bpu_pkg;

    localparam int unsigned INSTR_W = 32;

    // 2-bit saturating direction counters
    localparam logic [1:0] CTR_SNT  = 2'b00;
    localparam logic [1:0] CTR_WNT  = 2'b01;
    localparam logic [1:0] CTR_WT   = 2'b10;
    localparam logic [1:0] CTR_ST   = 2'b11;
    localparam logic [1:0] CTR_INIT = CTR_WNT;

    // REGIMM opcode and the beq/bne/blez/bgtz group (op[5:2] == 4'b0001)
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [3:0] OP_BGRP   = 4'b0001;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } bpu_state_e;

    // Saturating counter step toward the resolved direction
    function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic take);
        logic [1:0] nxt;
        if (take) begin
            nxt = (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
        end else begin
            nxt = (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/local_hist_bpu_if.sv
// Predict (D stage) and train (E stage) bus between the core front end and
// the branch predictor.
//   master: core side, drives D-stage instructions and E-stage outcomes
//   slave : predictor side, returns branch class, direction and PHT index
interface local_hist_bpu_if #(
    parameter int unsigned ISSUE_W   = 2,
    parameter int unsigned PHT_IDX_W = 8
) ();
    logic [ISSUE_W-1:0]           valid_d_i;
    logic [ISSUE_W*32-1:0]        instr_d_i;
    logic [ISSUE_W*32-1:0]        pc_d_i;
    logic [ISSUE_W-1:0]           is_branch_o;
    logic [ISSUE_W-1:0]           pred_take_o;
    logic [ISSUE_W*PHT_IDX_W-1:0] pred_pht_idx_o;
    logic [ISSUE_W-1:0]           upd_valid_i;
    logic [ISSUE_W*32-1:0]        upd_pc_i;
    logic [ISSUE_W*PHT_IDX_W-1:0] upd_pht_idx_i;
    logic [ISSUE_W-1:0]           upd_take_i;

    modport master (
        output valid_d_i, instr_d_i, pc_d_i,
        output upd_valid_i, upd_pc_i, upd_pht_idx_i, upd_take_i,
        input  is_branch_o, pred_take_o, pred_pht_idx_o
    );

    modport slave (
        input  valid_d_i, instr_d_i, pc_d_i,
        input  upd_valid_i, upd_pc_i, upd_pht_idx_i, upd_take_i,
        output is_branch_o, pred_take_o, pred_pht_idx_o
    );
endinterface

// File: rtl/bpu_branch_decode.sv
// Per-slot conditional branch classifier (combinational).
//   valid_i     : slot holds a real instruction
//   instr_i     : instruction word
//   is_branch_c : REGIMM bltz/bgez family or beq/bne/blez/bgtz
module bpu_branch_decode
    import bpu_pkg::*;
(
    input  logic               valid_i,
    input  logic [INSTR_W-1:0] instr_i,
    output logic               is_branch_c
);
    logic [5:0] op;
    logic       regimm_br;
    logic       grp_br;
    logic       unused_instr;

    assign op = instr_i[31:26];
    // instr[19:17] in {000,001} is the same as instr[19:18] == 00
    assign regimm_br    = (op == OP_REGIMM) && (instr_i[19:18] == 2'b00);
    assign grp_br       = (op[5:2] == OP_BGRP);
    assign is_branch_c  = valid_i & (regimm_br | grp_br);
    assign unused_instr = ^{instr_i[25:20], instr_i[17:0]};
endmodule

// File: rtl/local_hist_bpu.sv
// N-slot two-level local-history branch direction predictor.
//   clk, rst    : clock, asynchronous active-low reset
//   init_busy_o : table sweep in progress (predictions forced not-taken)
//   bus         : D-stage predict ports and E-stage train ports
// BHT holds per-PC history, PHT holds 2-bit counters indexed by
// history XOR pc. Tables are cleared by a sweep after reset instead of
// carrying an asynchronous reset.
module local_hist_bpu
    import bpu_pkg::*;
#(
    parameter int unsigned ISSUE_W   = 2,
    parameter int unsigned BHT_IDX_W = 10,
    parameter int unsigned HIST_W    = 6,
    parameter int unsigned PHT_IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    output logic             init_busy_o,
    local_hist_bpu_if.slave  bus
);
    localparam int unsigned MAX_IDX_W = (BHT_IDX_W > PHT_IDX_W) ? BHT_IDX_W : PHT_IDX_W;
    localparam int unsigned CNT_W     = MAX_IDX_W + 1;
    localparam int unsigned BHT_N     = 1 << BHT_IDX_W;
    localparam int unsigned PHT_N     = 1 << PHT_IDX_W;
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'((1 << MAX_IDX_W) - 1);

    bpu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;

    logic [HIST_W-1:0] bht_mem [BHT_N];
    logic [1:0]        pht_mem [PHT_N];

    logic [ISSUE_W-1:0]           is_br_c;
    logic [ISSUE_W-1:0]           pred_take_c;
    logic [ISSUE_W*PHT_IDX_W-1:0] pred_idx_c;
    logic [HIST_W-1:0]            hist_rd;
    logic [PHT_IDX_W-1:0]         idx_rd;

    logic [BHT_IDX_W-1:0] bht_wa [ISSUE_W];
    logic [HIST_W-1:0]    bht_wd [ISSUE_W];
    logic [PHT_IDX_W-1:0] pht_wa [ISSUE_W];
    logic [1:0]           pht_wd [ISSUE_W];
    logic [HIST_W-1:0]    hist_run;
    logic [1:0]           ctr_run;

    logic unused_pc;
    assign unused_pc = ^{bus.pc_d_i, bus.upd_pc_i};

    // Branch classification per slot
    for (genvar k = 0; k < ISSUE_W; k++) begin : g_dec
        bpu_branch_decode u_dec (
            .valid_i     (bus.valid_d_i[k]),
            .instr_i     (bus.instr_d_i[32*k +: 32]),
            .is_branch_c (is_br_c[k])
        );
    end

    // Sweep / run state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= INIT;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    // Next state: sweep every table address once, then run forever
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            INIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_TERM) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN:     state_d = RUN;
            default: state_d = INIT;
        endcase
        busy_d = (state_d == INIT);
    end

    // Prediction: reads see table contents before this cycle's writes
    always_comb begin
        pred_take_c = '0;
        pred_idx_c  = '0;
        hist_rd     = '0;
        idx_rd      = '0;
        for (int k = 0; k < ISSUE_W; k++) begin
            hist_rd = bht_mem[bus.pc_d_i[32*k+2 +: BHT_IDX_W]];
            idx_rd  = PHT_IDX_W'(hist_rd) ^ bus.pc_d_i[32*k+2 +: PHT_IDX_W];
            pred_idx_c[PHT_IDX_W*k +: PHT_IDX_W] = idx_rd;
            pred_take_c[k] = is_br_c[k] & pht_mem[idx_rd][1] & ~busy_q;
        end
    end

    // Update chain: each slot starts from the table value and replays every
    // older slot's outcome that hit the same entry, so younger slots see
    // older results while training only with their own outcome.
    always_comb begin
        hist_run = '0;
        ctr_run  = '0;
        for (int k = 0; k < ISSUE_W; k++) begin
            bht_wa[k] = bus.upd_pc_i[32*k+2 +: BHT_IDX_W];
            pht_wa[k] = bus.upd_pht_idx_i[PHT_IDX_W*k +: PHT_IDX_W];
            hist_run  = bht_mem[bus.upd_pc_i[32*k+2 +: BHT_IDX_W]];
            ctr_run   = pht_mem[bus.upd_pht_idx_i[PHT_IDX_W*k +: PHT_IDX_W]];
            for (int j = 0; j < ISSUE_W; j++) begin
                if (j < k && bus.upd_valid_i[j]) begin
                    if (bus.upd_pc_i[32*j+2 +: BHT_IDX_W] == bus.upd_pc_i[32*k+2 +: BHT_IDX_W]) begin
                        hist_run = {hist_run[HIST_W-2:0], bus.upd_take_i[j]};
                    end
                    if (bus.upd_pht_idx_i[PHT_IDX_W*j +: PHT_IDX_W] ==
                        bus.upd_pht_idx_i[PHT_IDX_W*k +: PHT_IDX_W]) begin
                        ctr_run = ctr_step(ctr_run, bus.upd_take_i[j]);
                    end
                end
            end
            bht_wd[k] = {hist_run[HIST_W-2:0], bus.upd_take_i[k]};
            pht_wd[k] = ctr_step(ctr_run, bus.upd_take_i[k]);
        end
    end

    // Table storage: sweep writes in INIT, trained writes in RUN; the
    // youngest colliding slot is written last and so wins.
    always_ff @(posedge clk) begin
        if (state_q == INIT) begin
            if (cnt_q < CNT_W'(BHT_N)) begin
                bht_mem[cnt_q[BHT_IDX_W-1:0]] <= '0;
            end
            if (cnt_q < CNT_W'(PHT_N)) begin
                pht_mem[cnt_q[PHT_IDX_W-1:0]] <= CTR_INIT;
            end
        end else begin
            for (int k = 0; k < ISSUE_W; k++) begin
                if (bus.upd_valid_i[k]) begin
                    bht_mem[bht_wa[k]] <= bht_wd[k];
                    pht_mem[pht_wa[k]] <= pht_wd[k];
                end
            end
        end
    end

    assign init_busy_o        = busy_q;
    assign bus.is_branch_o    = is_br_c;
    assign bus.pred_take_o    = pred_take_c;
    assign bus.pred_pht_idx_o = pred_idx_c;
endmodule

// File: tb/tb_local_hist_bpu.sv
// Scoreboard bench for local_hist_bpu: stimulus pushes expected predictions
// from a reference model of the tables; a negedge monitor pops and compares.
module tb_local_hist_bpu;

    logic clk = 1'b0;
    logic rst;
    logic init_busy;

    always #5 clk = ~clk;

    local_hist_bpu_if #(.ISSUE_W(2), .PHT_IDX_W(8)) bif ();

    local_hist_bpu #(
        .ISSUE_W   (2),
        .BHT_IDX_W (10),
        .HIST_W    (6),
        .PHT_IDX_W (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .init_busy_o (init_busy),
        .bus         (bif)
    );

    typedef struct {
        logic [1:0]      isb;
        logic [1:0]      take;
        logic [1:0][7:0] idx;
        bit              chk_idx;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    // Reference tables: history as an integer 0..63, counter as 0..3
    int bht_m [1024];
    int pht_m [256];
    int brt   [8] = '{0, 1, 2, 3, 16, 17, 18, 19};

    logic [31:0] d_instr [2];
    logic [31:0] d_pc    [2];
    logic        d_val   [2];
    logic        d_isbr  [2];
    logic        u_val   [2];
    logic [31:0] u_pc    [2];
    logic [7:0]  u_idx   [2];
    logic        u_take  [2];
    logic [1:0]  s_take;
    logic [7:0]  s_idx   [2];

    localparam logic [31:0] BEQ = 32'h1000_0000;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
        end
    endtask

    function automatic int bidx(input logic [31:0] pc);
        return int'((pc >> 2) & 32'h3ff);
    endfunction

    function automatic int pidx(input logic [31:0] pc);
        return bht_m[bidx(pc)] ^ int'((pc >> 2) & 32'hff);
    endfunction

    task automatic model_reset();
        foreach (bht_m[i]) bht_m[i] = 0;
        foreach (pht_m[i]) pht_m[i] = 1;
    endtask

    task automatic model_train(input logic [31:0] pc, input int idx, input logic take);
        int b;
        int c;
        b = bidx(pc);
        bht_m[b] = ((bht_m[b] * 2) + (take ? 1 : 0)) % 64;
        c = pht_m[idx];
        if (take) pht_m[idx] = (c == 3) ? 3 : c + 1;
        else      pht_m[idx] = (c == 0) ? 0 : c - 1;
    endtask

    task automatic gen_instr(input int kind, output logic [31:0] w, output logic br);
        int rt;
        w = $urandom;
        case (kind)
            0: begin
                w[31:26] = 6'(4 + $urandom_range(0, 3));
                br = 1'b1;
            end
            1: begin
                rt = brt[$urandom_range(0, 7)];
                w[31:26] = 6'd1;
                w[20:16] = 5'(rt);
                br = 1'b1;
            end
            2: begin
                rt = ($urandom_range(0, 1) == 1) ? 4 + int'($urandom_range(0, 11))
                                                 : 20 + int'($urandom_range(0, 11));
                w[31:26] = 6'd1;
                w[20:16] = 5'(rt);
                br = 1'b0;
            end
            default: begin
                rt = int'($urandom_range(0, 63));
                if (rt == 1 || (rt >= 4 && rt <= 7)) rt = 35;
                w[31:26] = 6'(rt);
                br = 1'b0;
            end
        endcase
    endtask

    function automatic logic [31:0] pick_pc();
        logic [31:0] pc;
        case ($urandom_range(0, 3))
            0:       pc = 32'h4000 + 32'(4 * $urandom_range(0, 7));
            1:       pc = 32'h4000 + 32'(4096 * $urandom_range(0, 2));
            2:       pc = 32'h4100 + 32'(4 * $urandom_range(0, 3));
            default: pc = $urandom & 32'hffff_fffc;
        endcase
        return pc;
    endfunction

    task automatic clear_stim();
        for (int k = 0; k < 2; k++) begin
            d_instr[k] = 32'h0;
            d_pc[k]    = 32'h0;
            d_val[k]   = 1'b0;
            d_isbr[k]  = 1'b0;
            u_val[k]   = 1'b0;
            u_pc[k]    = 32'h0;
            u_idx[k]   = 8'h0;
            u_take[k]  = 1'b0;
        end
    endtask

    task automatic rand_stim();
        logic [31:0] w;
        logic        br;
        for (int k = 0; k < 2; k++) begin
            gen_instr(int'($urandom_range(0, 3)), w, br);
            d_instr[k] = w;
            d_isbr[k]  = br;
            d_val[k]   = ($urandom_range(0, 3) != 0);
            d_pc[k]    = pick_pc();
            u_val[k]   = 1'($urandom_range(0, 1));
            u_pc[k]    = pick_pc();
            u_take[k]  = 1'($urandom_range(0, 1));
            u_idx[k]   = ($urandom_range(0, 1) == 1) ? 8'(pidx(u_pc[k])) : 8'($urandom);
        end
    endtask

    task automatic drive();
        bif.valid_d_i     = {d_val[1], d_val[0]};
        bif.instr_d_i     = {d_instr[1], d_instr[0]};
        bif.pc_d_i        = {d_pc[1], d_pc[0]};
        bif.upd_valid_i   = {u_val[1], u_val[0]};
        bif.upd_pc_i      = {u_pc[1], u_pc[0]};
        bif.upd_pht_idx_i = {u_idx[1], u_idx[0]};
        bif.upd_take_i    = {u_take[1], u_take[0]};
    endtask

    // One cycle: drive, push expectation, advance model, sample, clock
    task automatic step(input bit busy);
        exp_t e;
        logic isb;
        drive();
        e.chk_idx = !busy;
        for (int k = 0; k < 2; k++) begin
            isb       = d_val[k] & d_isbr[k];
            e.isb[k]  = isb;
            e.take[k] = !busy && isb && (pht_m[pidx(d_pc[k])] >= 2);
            e.idx[k]  = 8'(pidx(d_pc[k]));
        end
        if (d_val[0] || d_val[1]) sbq.push_back(e);
        if (!busy) begin
            for (int k = 0; k < 2; k++) begin
                if (u_val[k]) model_train(u_pc[k], int'(u_idx[k]), u_take[k]);
            end
        end
        #2;
        s_take   = bif.pred_take_o;
        s_idx[0] = bif.pred_pht_idx_o[7:0];
        s_idx[1] = bif.pred_pht_idx_o[15:8];
        @(posedge clk);
        #1;
    endtask

    task automatic probe(input logic [31:0] pc0, input logic [31:0] pc1);
        clear_stim();
        d_val[0] = 1'b1; d_isbr[0] = 1'b1; d_instr[0] = BEQ; d_pc[0] = pc0;
        d_val[1] = 1'b1; d_isbr[1] = 1'b1; d_instr[1] = BEQ; d_pc[1] = pc1;
        step(0);
    endtask

    task automatic upd2(input logic [31:0] pc0, input logic [7:0] i0, input logic t0,
                        input logic v1, input logic [31:0] pc1, input logic [7:0] i1, input logic t1);
        clear_stim();
        u_val[0] = 1'b1; u_pc[0] = pc0; u_idx[0] = i0; u_take[0] = t0;
        u_val[1] = v1;   u_pc[1] = pc1; u_idx[1] = i1; u_take[1] = t1;
        step(0);
    endtask

    // Runs random traffic while the sweep is busy; returns busy cycle count
    task automatic run_init(output int n);
        n = 0;
        for (int i = 0; i < 2000; i++) begin
            if (init_busy !== 1'b1) break;
            n++;
            rand_stim();
            step(1);
        end
        model_reset();
    endtask

    // Monitor: compare whenever the DUT sees a valid D-stage slot
    always @(negedge clk) begin
        exp_t e;
        if (bif.valid_d_i != 2'b00) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL scoreboard_empty got=valid_slot exp=queued_entry");
            end else begin
                e = sbq.pop_front();
                check("is_branch", 32'(bif.is_branch_o), 32'(e.isb));
                check("pred_take", 32'(bif.pred_take_o), 32'(e.take));
                if (e.chk_idx) begin
                    for (int k = 0; k < 2; k++) begin
                        if (bif.valid_d_i[k]) begin
                            check("pred_idx", 32'(bif.pred_pht_idx_o[8*k +: 8]), 32'(e.idx[k]));
                        end
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int mis;
        logic t;
        rst = 1'b1;
        clear_stim();
        drive();
        model_reset();
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // Reset: busy asserted, branches never predicted taken
        for (int i = 0; i < 3; i++) begin
            rand_stim();
            d_val[0] = 1'b1; d_isbr[0] = 1'b1; d_instr[0] = BEQ;
            step(1);
        end
        check("reset_busy", 32'(init_busy), 32'd1);
        check("reset_pred_take", 32'(s_take), 32'd0);

        rst = 1'b1;
        run_init(n);
        check("init_cycles", 32'(n), 32'd1024);
        check("init_done", 32'(init_busy), 32'd0);

        // Training at 0x1000: three takens grow history to 000111
        for (int i = 0; i < 3; i++) begin
            clear_stim();
            d_val[0] = 1'b1; d_isbr[0] = 1'b1; d_instr[0] = BEQ; d_pc[0] = 32'h1000;
            u_val[0] = 1'b1; u_pc[0] = 32'h1000; u_idx[0] = 8'(pidx(32'h1000)); u_take[0] = 1'b1;
            step(0);
            check("train_take_early", 32'(s_take[0]), 32'd0);
        end
        probe(32'h1000, 32'h1000);
        check("train_idx", 32'(s_idx[0]), 32'd7);
        check("train_take", 32'(s_take[0]), 32'd0);

        // Loop pattern T,T,T,N: no mispredicts once warmed up
        mis = 0;
        for (int it = 0; it < 200; it++) begin
            for (int p = 0; p < 4; p++) begin
                t = (p != 3);
                clear_stim();
                d_val[0] = 1'b1; d_isbr[0] = 1'b1; d_instr[0] = BEQ; d_pc[0] = 32'h2040;
                u_val[0] = 1'b1; u_pc[0] = 32'h2040; u_idx[0] = 8'(pidx(32'h2040)); u_take[0] = t;
                step(0);
                if (it >= 160 && s_take[0] != t) mis++;
            end
        end
        check("loop_mispredicts", 32'(mis), 32'd0);

        // Dual-slot collision T,T from 01: counter 11, history ...11
        upd2(32'h3010, 8'hAA, 1'b1, 1'b1, 32'h3010, 8'hAA, 1'b1);
        probe(32'h3010, 32'h02A8);
        check("coll_tt_hist", 32'(s_idx[0]), 32'd7);
        check("coll_tt_take", 32'(s_take[1]), 32'd1);
        upd2(32'h3010, 8'hAA, 1'b0, 1'b0, 32'h0, 8'h0, 1'b0);
        probe(32'h02A8, 32'h02A8);
        check("coll_tt_ctr11", 32'(s_take[0]), 32'd1);

        // Dual-slot collision T,N from 01: counter 01, history ...10
        upd2(32'h3020, 8'h55, 1'b1, 1'b1, 32'h3020, 8'h55, 1'b0);
        probe(32'h3020, 32'h0154);
        check("coll_tn_hist", 32'(s_idx[0]), 32'd10);
        check("coll_tn_take", 32'(s_take[1]), 32'd0);
        upd2(32'h3020, 8'h55, 1'b1, 1'b0, 32'h0, 8'h0, 1'b0);
        probe(32'h0154, 32'h0154);
        check("coll_tn_ctr01", 32'(s_take[0]), 32'd1);

        // Slot isolation: each slot shifts in its own outcome
        upd2(32'h3030, 8'h33, 1'b0, 1'b1, 32'h3050, 8'h66, 1'b1);
        probe(32'h3030, 32'h3050);
        check("iso_slot0", 32'(s_idx[0]), 32'h0C);
        check("iso_slot1", 32'(s_idx[1]), 32'h15);

        // Random traffic with frequent aliasing and same-cycle collisions
        for (int i = 0; i < 600; i++) begin
            rand_stim();
            step(0);
        end

        // Mid-run reset: asynchronous busy, full sweep, trained state gone
        clear_stim();
        drive();
        rst = 1'b0;
        #1;
        check("async_busy", 32'(init_busy), 32'd1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        run_init(n);
        check("reinit_cycles", 32'(n), 32'd1024);
        probe(32'h2040, 32'h1000);
        check("post_reset_take_a", 32'(s_take), 32'd0);
        probe(32'h02A8, 32'h3050);
        check("post_reset_take_b", 32'(s_take), 32'd0);

        clear_stim();
        step(0);
        step(0);
        check("sb_drain", 32'(sbq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/local_hist_bpu.md
Name: local_hist_bpu

Overview:
- Parametrised, N-slot local-history (two-level) branch direction predictor for the superscalar MIPS front end.
- Decodes branch class in D and predicts each slot from a per-PC history register (BHT) indexing a table of 2-bit counters (PHT).
- Trains from E. Each slot trains with its own outcome and the PHT index captured at prediction time.
- Clears its tables after reset with a sweep FSM, so no large asynchronous-reset array is needed.

Parameters:
- ISSUE_W, 2, number of issue slots (predict and update ports); slot 0 is oldest.
- BHT_IDX_W, 10, BHT has 2^BHT_IDX_W entries, indexed by pc[BHT_IDX_W+1:2].
- HIST_W, 6, bits of local history per BHT entry.
- PHT_IDX_W, 8, PHT has 2^PHT_IDX_W entries. Constraint: HIST_W <= PHT_IDX_W.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- init_busy_o  out  1  table sweep in progress
- valid_d_i  in  ISSUE_W  slot holds a real instruction in D
- instr_d_i  in  ISSUE_W*32  D-stage instruction words, slot k at [32k+:32]
- pc_d_i  in  ISSUE_W*32  D-stage PCs
- is_branch_o  out  ISSUE_W  slot is a conditional branch
- pred_take_o  out  ISSUE_W  predicted taken
- pred_pht_idx_o  out  ISSUE_W*PHT_IDX_W  PHT index used for the prediction; pipelined to E by the core
- upd_valid_i  in  ISSUE_W  slot is a resolved conditional branch in E
- upd_pc_i  in  ISSUE_W*32  E-stage PCs
- upd_pht_idx_i  in  ISSUE_W*PHT_IDX_W  index carried from D
- upd_take_i  in  ISSUE_W  actual direction

Behaviour:
- Branch decode (combinational), per slot:
  - is_branch = valid & ((op==REGIMM & instr[19:17] in {000,001}) | op[5:2]==4'b0001).
- Prediction (combinational, zero latency):
  - hist = BHT[pc[BHT_IDX_W+1:2]].
  - idx = zero-extended hist XOR pc[PHT_IDX_W+1:2].
  - pred_take = is_branch & PHT[idx][1] & ~init_busy_o.
  - Reads return pre-update (old) values when a same-cycle write hits the same entry.
- Counters: 00 strongly not-taken, 01 weakly not-taken, 10 weakly taken, 11 strongly taken.
  - Taken: saturating +1. Not taken: saturating -1.
- Update, one clock edge, slots applied in order 0..ISSUE_W-1:
  - BHT[upd_pc] <= {hist[HIST_W-2:0], upd_take}.
  - PHT[upd_pht_idx] <= counter stepped by upd_take.
  - If slots collide on the same BHT or PHT entry, the younger slot operates on the older slot's result. Example: two takens on 01 give 11; two shifts of history 000001 with 1 then 0 give 000110.
  - Slot k trains only with upd_take[k], never with another slot's outcome.
- FSM, states INIT and RUN:
  - rst low: asynchronously enter INIT with sweep counter 0; init_busy_o=1.
  - INIT, each cycle: write BHT[cnt]=0 (cnt < 2^BHT_IDX_W) and PHT[cnt]=01 (cnt < 2^PHT_IDX_W).
  - INIT, the cycle after cnt = 2^max(BHT_IDX_W,PHT_IDX_W)-1: move to RUN, init_busy_o=0. Defaults: 1024 INIT cycles.
  - INIT: upd_valid_i is ignored and pred_take_o=0. is_branch_o stays live.
  - RUN: normal operation; stays in RUN until rst.
  - rst asserted mid-sweep or mid-RUN: restart INIT from 0; table contents are don't-care until the sweep rewrites them.
- Reset output values:
  - init_busy_o=1, pred_take_o=0.
  - is_branch_o and pred_pht_idx_o are combinational from the inputs.
  - Table arrays carry no asynchronous reset.
- Width rules:
  - The sweep counter is max(BHT_IDX_W,PHT_IDX_W)+1 bits to detect the terminal count.
  - Index slicing wraps naturally: aliasing PCs share entries.

Decomposition:
- Package bpu_pkg:
  - counter encodings SNT/WNT/WT/ST and the init value WNT.
  - opcode constants REGIMM and the beq/bne/blez/bgtz group.
  - function ctr_step(ctr, take).
  - enum bpu_state_e {INIT, RUN}.
- One sub-module, bpu_branch_decode: per-slot combinational branch classifier, instantiated ISSUE_W times.
- Table storage and the update/collision chain live in local_hist_bpu.

Test Plan:
- Reset release: hold rst=0 for 3 cycles, release. Expect init_busy_o=1 for exactly 1024 cycles, then 0; no branch predicted taken.
- Training: after init, update pc=0x1000 taken 3 times. The prediction index changes as history grows; expect prediction idx = (hist 000111) XOR pc[9:2], and pred_take=0 until the counter at that index reaches 10.
- Loop pattern: 200 iterations of T,T,T,N at pc 0x2040. Expect steady-state mispredict count 0 over the last 40 iterations.
- Dual-slot collision: both slots update the same pc and same idx with take=1,1 from counter 01. Expect counter 11 and BHT low bits ...11. With take=1,0, expect counter 01 and history ...10.
- Slot isolation: slot0 not-taken, slot1 taken on different PCs. Expect slot1's BHT entry ends in 1 and slot0's ends in 0.
- Mid-run reset: drop rst during RUN. Expect init_busy_o=1 asynchronously and a full 1024-cycle sweep; afterwards every previously trained PC predicts not-taken.
